// File: rtl/des_crypt_unrolled.sv
// des_crypt_unrolled: iterative DES encrypt/decrypt core that runs UNROLL rounds per clock.
// A block takes 16/UNROLL round cycles. done pulses in the cycle after the last round edge.
// Ports:
//   clk, rst (async active-high)
//   start/decrypt/message/round_keys: sampled together while busy=0
//   busy/done/result: status and registered ciphertext/plaintext
// Build option: define DES_DECRYPT_EN to honour `decrypt`. Without it the core
// always encrypts and only the left-shift key path exists.
// Bit numbering follows DES convention: index 1 is the MSB of every vector.

// Initial permutation IP, pure wiring.
module ip_permutation (
  input  logic [1:64] din,
  output logic [1:64] dout
);
  localparam int TAB [64] = '{
    58, 50, 42, 34, 26, 18, 10,  2,  60, 52, 44, 36, 28, 20, 12,  4,
    62, 54, 46, 38, 30, 22, 14,  6,  64, 56, 48, 40, 32, 24, 16,  8,
    57, 49, 41, 33, 25, 17,  9,  1,  59, 51, 43, 35, 27, 19, 11,  3,
    61, 53, 45, 37, 29, 21, 13,  5,  63, 55, 47, 39, 31, 23, 15,  7};

  always_comb begin
    dout = '0;
    for (int i = 0; i < 64; i++) dout[i+1] = din[TAB[i]];
  end
endmodule

// Final permutation IP^-1, pure wiring.
module ip_inverse_permutation (
  input  logic [1:64] din,
  output logic [1:64] dout
);
  localparam int TAB [64] = '{
    40,  8, 48, 16, 56, 24, 64, 32,  39,  7, 47, 15, 55, 23, 63, 31,
    38,  6, 46, 14, 54, 22, 62, 30,  37,  5, 45, 13, 53, 21, 61, 29,
    36,  4, 44, 12, 52, 20, 60, 28,  35,  3, 43, 11, 51, 19, 59, 27,
    34,  2, 42, 10, 50, 18, 58, 26,  33,  1, 41,  9, 49, 17, 57, 25};

  always_comb begin
    dout = '0;
    for (int i = 0; i < 64; i++) dout[i+1] = din[TAB[i]];
  end
endmodule

module des_crypt_unrolled #(
  parameter int UNROLL = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         decrypt,
  input  logic [1:64]  message,
  input  logic [1:768] round_keys,
  output logic         busy,
  output logic         done,
  output logic [1:64]  result
);

  localparam int        NCYC = 16 / UNROLL;
  localparam logic [3:0] LAST = 4'(NCYC - 1);
  localparam int        KSH  = 48 * UNROLL;

  generate
    if (UNROLL != 1 && UNROLL != 2 && UNROLL != 4 && UNROLL != 8 && UNROLL != 16) begin : g_bad_unroll
      $error("des_crypt_unrolled: UNROLL must be 1, 2, 4, 8 or 16");
    end
  endgenerate

  // E-expansion selection table
  localparam int E_TAB [48] = '{
    32,  1,  2,  3,  4,  5,   4,  5,  6,  7,  8,  9,
     8,  9, 10, 11, 12, 13,  12, 13, 14, 15, 16, 17,
    16, 17, 18, 19, 20, 21,  20, 21, 22, 23, 24, 25,
    24, 25, 26, 27, 28, 29,  28, 29, 30, 31, 32,  1};

  // P permutation applied to the S-box outputs
  localparam int P_TAB [32] = '{
    16,  7, 20, 21, 29, 12, 28, 17,   1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9,  19, 13, 30,  6, 22, 11,  4, 25};

  // S1..S8, 64 nibbles each, row-major (row*16+col), S1 in the top 256 bits
  localparam logic [2047:0] SBOX = {
    256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
    256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
    256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
    256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
    256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
    256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
    256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
    256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B};

  // DES round function f(R, K)
  function automatic logic [1:32] feistel(input logic [1:32] rin, input logic [1:48] key);
    logic [1:48] x;
    logic [1:32] s;
    logic [1:32] p;
    logic [5:0]  six;
    logic [5:0]  idx;
    for (int i = 0; i < 48; i++) x[i+1] = rin[E_TAB[i]] ^ key[i+1];
    for (int b = 0; b < 8; b++) begin
      six = x[6*b+1 +: 6];
      // outer bits pick the row, inner four bits pick the column
      idx = {six[5], six[0], six[4:1]};
      s[4*b+1 +: 4] = SBOX[2047 - 256*b - 4*int'(idx) -: 4];
    end
    for (int i = 0; i < 32; i++) p[i+1] = s[P_TAB[i]];
    return p;
  endfunction

  typedef enum logic {IDLE = 1'b0, ROUNDS = 1'b1} state_t;

  state_t       state;
  state_t       state_nxt;
  logic [3:0]   cnt;
  logic [1:32]  l;
  logic [1:32]  r;
  logic [1:768] kreg;
  logic         accept;
  logic         last;
  logic [1:64]  ip_out;
  logic [1:64]  fp_out;
  logic [1:32]  lc [0:UNROLL];
  logic [1:32]  rc [0:UNROLL];

`ifdef DES_DECRYPT_EN
  logic mode;
`else
  logic unused_decrypt;
  assign unused_decrypt = decrypt;
`endif

  assign accept = (state == IDLE) && start;
  assign last   = (state == ROUNDS) && (cnt == LAST);

  ip_permutation u_ip (
    .din  (message),
    .dout (ip_out)
  );

  // Chain of UNROLL rounds evaluated in one cycle
  assign lc[0] = l;
  assign rc[0] = r;

  genvar g;
  generate
    for (g = 0; g < UNROLL; g++) begin : g_round
      logic [1:48] k;
`ifdef DES_DECRYPT_EN
      // decrypt draws keys from the bottom of the register (K16 first)
      assign k = mode ? kreg[769-48*(g+1) +: 48] : kreg[48*g+1 +: 48];
`else
      assign k = kreg[48*g+1 +: 48];
`endif
      assign lc[g+1] = rc[g];
      assign rc[g+1] = lc[g] ^ feistel(rc[g], k);
    end
  endgenerate

  // The last round has no swap, so undo the chain's swap here: R16 || L16
  ip_inverse_permutation u_fp (
    .din  ({rc[UNROLL], lc[UNROLL]}),
    .dout (fp_out)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = ROUNDS;
      ROUNDS:  if (cnt == LAST) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy = (state == ROUNDS);
  end

  // Datapath, counter and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      l      <= '0;
      r      <= '0;
      kreg   <= '0;
      cnt    <= '0;
      done   <= 1'b0;
      result <= '0;
`ifdef DES_DECRYPT_EN
      mode   <= 1'b0;
`endif
    end else begin
      done <= last;
      if (accept) begin
        l    <= ip_out[1:32];
        r    <= ip_out[33:64];
        kreg <= round_keys;
        cnt  <= '0;
`ifdef DES_DECRYPT_EN
        mode <= decrypt;
`endif
      end else if (busy) begin
        l <= lc[UNROLL];
        r <= rc[UNROLL];
`ifdef DES_DECRYPT_EN
        kreg <= mode ? (kreg >> KSH) : (kreg << KSH);
`else
        kreg <= kreg << KSH;
`endif
        cnt <= last ? 4'd0 : cnt + 4'd1;
      end
      if (last) result <= fp_out;
    end
  end

endmodule

// File: tb/tb_des_crypt_unrolled.sv
module tb_des_crypt_unrolled #(
  parameter int UNR = 2
);

  localparam int N = 16 / UNR;
`ifdef DES_DECRYPT_EN
  localparam bit DEC_EN = 1'b1;
`else
  localparam bit DEC_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         decrypt;
  logic [63:0]  message;
  logic [767:0] round_keys;
  logic         busy;
  logic         done;
  logic [63:0]  result;

  int total = 0;
  int bad   = 0;

  des_crypt_unrolled #(.UNROLL(UNR)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .decrypt    (decrypt),
    .message    (message),
    .round_keys (round_keys),
    .busy       (busy),
    .done       (done),
    .result     (result)
  );

  always #5 clk = ~clk;

  // ---------------- reference model (FIPS 46 tables, DES bit n = word[W-n]) ----------------
  localparam int PC1 [56] = '{57,49,41,33,25,17,9, 1,58,50,42,34,26,18, 10,2,59,51,43,35,27,
    19,11,3,60,52,44,36, 63,55,47,39,31,23,15, 7,62,54,46,38,30,22, 14,6,61,53,45,37,29,
    21,13,5,28,20,12,4};
  localparam int PC2 [48] = '{14,17,11,24,1,5, 3,28,15,6,21,10, 23,19,12,4,26,8, 16,7,27,20,13,2,
    41,52,31,37,47,55, 30,40,51,45,33,48, 44,49,39,56,34,53, 46,42,50,36,29,32};
  localparam int PT [32] = '{16,7,20,21,29,12,28,17, 1,15,23,26,5,18,31,10,
    2,8,24,14,32,27,3,9, 19,13,30,6,22,11,4,25};
  localparam int SHIFTS [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};
  localparam int SB [512] = '{
    14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7,     0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
    4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0,     15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13,
    15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10,     3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
    0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15,     13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9,
    10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8,     13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
    13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7,     1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12,
    7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15,     13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
    10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4,     3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14,
    2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9,     14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
    4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14,     11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3,
    12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11,     10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
    9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6,     4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13,
    4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1,     13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
    1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2,     6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12,
    13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7,     1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
    7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8,     2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11};

  // IP source bit for output bit i: columns of even bits then odd bits, read bottom-up
  function automatic int ip_src(input int i);
    int rw, cl;
    rw = (i - 1) / 8;
    cl = (i - 1) % 8;
    return (rw < 4) ? (58 + 2*rw - 8*cl) : (57 + 2*(rw - 4) - 8*cl);
  endfunction

  function automatic logic [63:0] ip_ref(input logic [63:0] x);
    logic [63:0] y;
    for (int i = 1; i <= 64; i++) y[64-i] = x[64-ip_src(i)];
    return y;
  endfunction

  function automatic logic [63:0] fp_ref(input logic [63:0] x);
    logic [63:0] y;
    for (int i = 1; i <= 64; i++) y[64-ip_src(i)] = x[64-i];
    return y;
  endfunction

  function automatic logic [31:0] f_ref(input logic [31:0] rv, input logic [47:0] k);
    logic [47:0] e;
    logic [31:0] s;
    logic [31:0] p;
    logic [5:0]  six;
    int          src, row, col, v;
    for (int i = 0; i < 48; i++) begin
      src = ((4*(i/6) + (i%6) + 31) % 32) + 1;
      e[47-i] = rv[32-src];
    end
    e = e ^ k;
    for (int b = 0; b < 8; b++) begin
      six = e[47-6*b -: 6];
      row = 2*int'(six[5]) + int'(six[0]);
      col = int'(six[4:1]);
      v   = SB[b*64 + row*16 + col];
      s[31-4*b -: 4] = v[3:0];
    end
    for (int i = 0; i < 32; i++) p[31-i] = s[32-PT[i]];
    return p;
  endfunction

  function automatic logic [767:0] ksched(input logic [63:0] key);
    logic [55:0]  cd;
    logic [27:0]  c, d;
    logic [47:0]  k;
    logic [767:0] ks;
    for (int i = 0; i < 56; i++) cd[55-i] = key[64-PC1[i]];
    c  = cd[55:28];
    d  = cd[27:0];
    ks = '0;
    for (int rd = 0; rd < 16; rd++) begin
      for (int s = 0; s < SHIFTS[rd]; s++) begin
        c = {c[26:0], c[27]};
        d = {d[26:0], d[27]};
      end
      cd = {c, d};
      for (int i = 0; i < 48; i++) k[47-i] = cd[56-PC2[i]];
      ks = {ks[719:0], k};
    end
    return ks;
  endfunction

  function automatic logic [63:0] des_ref(input logic [63:0] msg, input logic [767:0] ks, input bit dec);
    logic [63:0] x;
    logic [31:0] lv, rv, t;
    int          idx;
    x  = ip_ref(msg);
    lv = x[63:32];
    rv = x[31:0];
    for (int rd = 0; rd < 16; rd++) begin
      idx = dec ? 15 - rd : rd;
      t   = rv;
      rv  = lv ^ f_ref(rv, ks[767-48*idx -: 48]);
      lv  = t;
    end
    return fp_ref({rv, lv});
  endfunction

  function automatic logic [63:0] rnd64();
    return {$urandom(), $urandom()};
  endfunction

  function automatic logic [767:0] rnd768();
    logic [767:0] v;
    for (int i = 0; i < 24; i++) v[32*i +: 32] = $urandom();
    return v;
  endfunction

  // ---------------- checking and driving helpers ----------------
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // drive a request now and let the next rising edge sample it, then scramble inputs
  task automatic start_now(input logic [63:0] msg, input logic [767:0] ks, input bit dec);
    message    = msg;
    round_keys = ks;
    decrypt    = dec;
    start      = 1'b1;
    @(posedge clk);
    #1;
    start      = 1'b0;
    message    = rnd64();
    round_keys = rnd768();
    decrypt    = ~dec;
  endtask

  task automatic do_start(input logic [63:0] msg, input logic [767:0] ks, input bit dec);
    @(negedge clk);
    start_now(msg, ks, dec);
  endtask

  // count edges after the start edge until done is seen, bounded
  task automatic wait_done(output int lat);
    lat = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk);
      #1;
      lat++;
      if (done) break;
    end
  endtask

  task automatic count_done(input int cycles, output int nd);
    nd = 0;
    repeat (cycles) begin
      @(posedge clk);
      #1;
      if (done) nd++;
    end
  endtask

  task automatic run_blk(input string tag, input logic [63:0] msg, input logic [767:0] ks,
                         input bit dec, input logic [63:0] exp);
    int lat;
    do_start(msg, ks, dec);
    chk({tag, "_busy"}, 64'(busy), 64'd1);
    wait_done(lat);
    chk({tag, "_lat"}, 64'(lat), 64'(N));
    chk({tag, "_res"}, result, exp);
    chk({tag, "_idle"}, 64'(busy), 64'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [767:0] ks_a, ks_b, ks_r;
    logic [63:0]  m, ma, mb, mr;
    int           lat, nd;
    bit           dec;

    rst = 1'b1; start = 1'b0; decrypt = 1'b0; message = '0; round_keys = '0;
    ks_a = ksched(64'h133457799BBCDFF1);
    ks_b = ksched(64'h0E329232EA6D0D73);
    #2;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_result", result, 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // known-answer encryption
    run_blk("enc_kat", 64'h0123456789ABCDEF, ks_a, 1'b0, 64'h85E813540F0AB405);
`ifdef DES_DECRYPT_EN
    run_blk("dec_kat", 64'h85E813540F0AB405, ks_a, 1'b1, 64'h0123456789ABCDEF);
`else
    run_blk("dec_ignored", 64'h0123456789ABCDEF, ks_a, 1'b1, 64'h85E813540F0AB405);
`endif

    // second known answer, then a new start in the done cycle
    run_blk("enc_kat2", 64'h8787878787878787, ks_b, 1'b0, 64'h0000000000000000);
    m = rnd64();
    start_now(m, ks_a, 1'b0);
    chk("b2b_busy", 64'(busy), 64'd1);
    wait_done(lat);
    chk("b2b_lat", 64'(lat), 64'(N));
    chk("b2b_res", result, des_ref(m, ks_a, 1'b0));

    // start while busy is dropped
    ma = rnd64();
    mb = rnd64();
    do_start(ma, ks_a, 1'b0);
    start = 1'b1; message = mb; round_keys = ks_b;
    lat = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk);
      #1;
      lat++;
      start = 1'b0;
      if (done) break;
    end
    chk("mid_lat", 64'(lat), 64'(N));
    chk("mid_res", result, des_ref(ma, ks_a, 1'b0));
    count_done(N + 3, nd);
    chk("mid_no_second_done", 64'(nd), 64'd0);
    chk("mid_idle", 64'(busy), 64'd0);

    // asynchronous reset in the middle of a block
    do_start(rnd64(), ks_b, 1'b0);
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_done", 64'(done), 64'd0);
    chk("arst_result", result, 64'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    count_done(N + 3, nd);
    chk("arst_no_done", 64'(nd), 64'd0);
    run_blk("post_rst", 64'h0123456789ABCDEF, ks_a, 1'b0, 64'h85E813540F0AB405);

    // random blocks against the reference model
    for (int t = 0; t < 24; t++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      mr   = rnd64();
      dec  = 1'($urandom_range(0, 1));
      ks_r = t[0] ? ksched(rnd64()) : rnd768();
      run_blk($sformatf("rand%0d", t), mr, ks_r, dec, des_ref(mr, ks_r, dec & DEC_EN));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
